serial_addsub_ctrl: RTL and testbench

//  Bit-serial N-bit adder/subtractor controller built around one fas bit cell.

---
 rtl/serial_pkg.sv | 14 +
 rtl/fas.sv | 19 +
 rtl/serial_addsub_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and mode encoding for the bit-serial add/sub controller.
// Package only: no timing and no flow control.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ser_state_t;

   localparam logic MODE_ADD = 1'b1;
   localparam logic MODE_SUB = 1'b0;

endpackage

// File: rtl/fas.sv
// One-bit full adder/subtractor cell: s = a^b^cin; cout is carry (a_ns=1) or borrow (a_ns=0).
// Purely combinational, so there is no latency and no backpressure.
module fas (
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic a_ns,
   output logic s,
   output logic cout
);

   logic a_eff;

   // In subtract mode A is complemented only in the carry path, turning the majority into a borrow.
   assign a_eff = ~(a ^ a_ns);
   assign s     = a ^ b ^ cin;
   assign cout  = (a_eff & (b | cin)) | (b & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial N-bit add/sub around one fas cell, LSB first, one bit per clock.
// Latency: start accept to done is N edges; start is ignored while busy, so there is no queueing.
module serial_addsub_ctrl
   import serial_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a_in,
   input  logic [N-1:0] b_in,
   input  logic         a_ns_in,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         cout_out
);

   localparam int CNT_W = $clog2(N + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

   ser_state_t state;
   ser_state_t state_nxt;

   logic [N-1:0]     a_sr;
   logic [N-1:0]     b_sr;
   logic [N-1:0]     s_sr;
   logic             carry_q;
   logic             mode_q;
   logic [CNT_W-1:0] cnt;

   logic accept;
   logic step;
   logic last_step;

   logic fas_s;
   logic fas_cout;

   // Cell inputs come only from flops, so the cell delay is the only combinational stage per clock.
   fas u_fas (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry_q),
      .a_ns (mode_q),
      .s    (fas_s),
      .cout (fas_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      step      = 1'b0;
      last_step = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (cnt == LAST_BIT) begin
               last_step = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr     <= '0;
         b_sr     <= '0;
         s_sr     <= '0;
         carry_q  <= 1'b0;
         mode_q   <= MODE_SUB;
         cnt      <= '0;
         result   <= '0;
         cout_out <= 1'b0;
      end else if (accept) begin
         a_sr    <= a_in;
         b_sr    <= b_in;
         mode_q  <= a_ns_in;
         carry_q <= 1'b0;
         cnt     <= '0;
      end else if (step) begin
         a_sr    <= {1'b0, a_sr[N-1:1]};
         b_sr    <= {1'b0, b_sr[N-1:1]};
         s_sr    <= {fas_s, s_sr[N-1:1]};
         carry_q <= fas_cout;
         cnt     <= cnt + CNT_W'(1);
         // Outputs move only on the final bit so they never show a partial sum.
         if (last_step) begin
            result   <= {fas_s, s_sr[N-1:1]};
            cout_out <= fas_cout;
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Bench for serial_addsub_ctrl: arithmetic-level model checked every cycle, plus directed literals.
module tb_serial_addsub_ctrl;
   import serial_pkg::*;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] a_in;
   logic [N-1:0] b_in;
   logic         a_ns_in;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic         cout_out;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   serial_addsub_ctrl #(.N(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a_in     (a_in),
      .b_in     (b_in),
      .a_ns_in  (a_ns_in),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout_out (cout_out)
   );

   always #20 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model: an accepted operation occupies N+1 busy cycles, the last of which shows done.
   int           m_left = 0;
   logic [N-1:0] m_res  = '0;
   logic         m_cout = 1'b0;
   logic [N-1:0] p_res  = '0;
   logic         p_cout = 1'b0;
   logic [N:0]   sum;

   always @(posedge clk) begin
      if (rst) begin
         m_left = 0;
         m_res  = '0;
         m_cout = 1'b0;
      end else if (m_left == 0) begin
         if (start) begin
            if (a_ns_in == MODE_ADD) begin
               sum    = {1'b0, a_in} + {1'b0, b_in};
               p_res  = sum[N-1:0];
               p_cout = sum[N];
            end else begin
               p_res  = a_in - b_in;
               p_cout = (a_in < b_in);
            end
            m_left = N + 1;
         end
      end else begin
         m_left = m_left - 1;
         if (m_left == 1) begin
            m_res  = p_res;
            m_cout = p_cout;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_busy", {31'd0, busy}, {31'd0, m_left > 0});
         chk("cyc_done", {31'd0, done}, {31'd0, m_left == 1});
         chk("cyc_result", {24'd0, result}, {24'd0, m_res});
         chk("cyc_cout", {31'd0, cout_out}, {31'd0, m_cout});
      end
   end

   task automatic run_op(input logic md, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] er, input logic ec, input string nm);
      int lat;
      int bcyc;
      bit seen;
      lat  = 0;
      bcyc = 0;
      seen = 1'b0;
      @(negedge clk);
      a_in    = a;
      b_in    = b;
      a_ns_in = md;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         if (busy) bcyc++;
         if (done && !seen) begin
            seen = 1'b1;
            lat  = k;
            chk({nm, "_result"}, {24'd0, result}, {24'd0, er});
            chk({nm, "_cout"}, {31'd0, cout_out}, {31'd0, ec});
            chk({nm, "_model"}, {24'd0, m_res}, {24'd0, er});
         end
         if (!busy) break;
         @(negedge clk);
      end
      chk({nm, "_done_seen"}, {31'd0, seen}, 32'd1);
      chk({nm, "_latency"}, lat, N + 1);
      chk({nm, "_busy_cycles"}, bcyc, N + 1);
   endtask

   initial begin
      int done_at[$];
      logic [N-1:0] done_res[$];
      int ndone;
      rst     = 1'b1;
      start   = 1'b0;
      a_in    = '0;
      b_in    = '0;
      a_ns_in = MODE_SUB;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_result", {24'd0, result}, 32'd0);
      chk("rst_cout", {31'd0, cout_out}, 32'd0);
      rst    = 1'b0;
      chk_en = 1'b1;

      run_op(MODE_ADD, 8'h5A, 8'h3C, 8'h96, 1'b0, "add_5a_3c");
      run_op(MODE_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, "add_ff_01");
      run_op(MODE_SUB, 8'h10, 8'h01, 8'h0F, 1'b0, "sub_10_01");
      run_op(MODE_SUB, 8'h01, 8'h02, 8'hFF, 1'b1, "sub_01_02");
      run_op(MODE_SUB, 8'h80, 8'h80, 8'h00, 1'b0, "sub_80_80");

      // Continuous start with operands changing every cycle.
      @(negedge clk);
      a_ns_in = MODE_ADD;
      start   = 1'b1;
      for (int i = 0; i < 30; i++) begin
         a_in = 8'(i * 7 + 3);
         b_in = 8'(i * 3 + 1);
         @(negedge clk);
         if (done) begin
            done_at.push_back(i);
            done_res.push_back(result);
         end
      end
      start = 1'b0;
      chk("stream_count", done_at.size(), 3);
      if (done_at.size() == 3) begin
         chk("stream_res0", {24'd0, done_res[0]}, 32'h04);
         chk("stream_res1", {24'd0, done_res[1]}, 32'h68);
         chk("stream_res2", {24'd0, done_res[2]}, 32'hCC);
         chk("stream_gap1", done_at[1] - done_at[0], N + 2);
         chk("stream_gap2", done_at[2] - done_at[1], N + 2);
      end
      repeat (3) @(negedge clk);

      // Reset sampled at the fourth bit edge of a run.
      a_in    = 8'hF0;
      b_in    = 8'h0F;
      a_ns_in = MODE_ADD;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_result", {24'd0, result}, 32'd0);
      chk("abort_cout", {31'd0, cout_out}, 32'd0);
      rst   = 1'b0;
      ndone = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("abort_no_done", ndone, 0);

      run_op(MODE_ADD, 8'h01, 8'h01, 8'h02, 1'b0, "add_01_01");

      @(negedge clk);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      failures++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
